cordic_post_scale: RTL

Output post-processing stage placed directly downstream of the CORDIC vectoring core. It takes the core's raw, gain-inflated magnitude and radian angle, applies the CORDIC gain compensation `K_SCALED[K_INDEX]`, and converts the angle to degrees with `T_SCALED`. Each result is rounded and saturated. Data moves through a two-stage valid/ready pipeline that propagates stalls, so the block can sit between the core and any back-pressuring consumer.

---
 rtl/cordic_post_scale.sv | 115 +++++++++++
 1 files changed

// File: rtl/cordic_post_scale.sv
// CORDIC output post-processing: gain compensation of the magnitude and radian-to-degree
// conversion of the angle, each rounded symmetrically and saturated, behind a 2-deep valid/ready pipe.

package settings_pkg;
    localparam int FULL_SIZE = 37;
    localparam int FRAC_SIZE = 16;
    localparam int K_STAGES  = 9;
    // Cumulative CORDIC gain compensation prod(1/sqrt(1+2^-2i)), i=0..n, scaled by 2^FRAC_SIZE
    localparam int K_SCALED [K_STAGES] = '{46341, 41448, 40211, 39901, 39823, 39803, 39799, 39797, 39797};
    // 180/pi scaled by 2^FRAC_SIZE
    localparam int T_SCALED = 3754936;
endpackage

module cordic_post_scale #(
    parameter int FULL_SIZE = settings_pkg::FULL_SIZE,
    parameter int FRAC_SIZE = settings_pkg::FRAC_SIZE,
    parameter int K_INDEX   = settings_pkg::K_STAGES - 1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [FULL_SIZE-1:0] in_x,
    input  logic signed [FULL_SIZE-1:0] in_z,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [FULL_SIZE-1:0] out_mag,
    output logic signed [FULL_SIZE-1:0] out_deg,
    output logic                        out_ovf
);
    localparam int PW = 2 * FULL_SIZE;
    localparam logic signed [PW-1:0] K_C  = PW'(settings_pkg::K_SCALED[K_INDEX]);
    localparam logic signed [PW-1:0] T_C  = PW'(settings_pkg::T_SCALED);
    localparam logic [PW:0]          HALF = (PW+1)'(1) << (FRAC_SIZE - 1);
    localparam logic [PW:0]          MAXV = ((PW+1)'(1) << (FULL_SIZE - 1)) - (PW+1)'(1);

    logic                        s1_v_q, s1_v_d;
    logic                        s2_v_q, s2_v_d;
    logic signed [PW-1:0]        px_q, px_d;
    logic signed [PW-1:0]        pz_q, pz_d;
    logic signed [FULL_SIZE-1:0] mag_q, mag_d;
    logic signed [FULL_SIZE-1:0] deg_q, deg_d;
    logic                        ovf_q, ovf_d;
    logic                        s1_load, s2_load;
    logic signed [PW-1:0]        x_ext, z_ext;
    logic [FULL_SIZE:0]          mag_rs, deg_rs;

    // Round half away from zero on the magnitude, clamp symmetrically; returns {ovf, value}
    function automatic logic [FULL_SIZE:0] round_sat(input logic signed [PW-1:0] p);
        logic [PW:0]          a;
        logic [PW:0]          q;
        logic [FULL_SIZE-1:0] m;
        logic                 ovf;
        a   = p[PW-1] ? -{1'b1, p} : {1'b0, p};
        q   = (a + HALF) >> FRAC_SIZE;
        ovf = (q > MAXV);
        m   = ovf ? MAXV[FULL_SIZE-1:0] : q[FULL_SIZE-1:0];
        return {ovf, (p[PW-1] ? -m : m)};
    endfunction

    always_comb begin
        in_ready = !s1_v_q || !s2_v_q || out_ready;
        s1_load  = in_valid && in_ready;
        s2_load  = s1_v_q && (!s2_v_q || out_ready);

        s1_v_d = s1_load ? 1'b1 : (s2_load ? 1'b0 : s1_v_q);
        s2_v_d = s2_load ? 1'b1 : (out_ready ? 1'b0 : s2_v_q);

        x_ext = {{FULL_SIZE{in_x[FULL_SIZE-1]}}, in_x};
        z_ext = {{FULL_SIZE{in_z[FULL_SIZE-1]}}, in_z};
        px_d  = px_q;
        pz_d  = pz_q;
        if (s1_load) begin
            px_d = x_ext * K_C;
            pz_d = z_ext * T_C;
        end

        mag_rs = round_sat(px_q);
        deg_rs = round_sat(pz_q);
        mag_d  = mag_q;
        deg_d  = deg_q;
        ovf_d  = ovf_q;
        if (s2_load) begin
            mag_d = mag_rs[FULL_SIZE-1:0];
            deg_d = deg_rs[FULL_SIZE-1:0];
            ovf_d = mag_rs[FULL_SIZE] | deg_rs[FULL_SIZE];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_v_q <= 1'b0;
            s2_v_q <= 1'b0;
            px_q   <= '0;
            pz_q   <= '0;
            mag_q  <= '0;
            deg_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            s1_v_q <= s1_v_d;
            s2_v_q <= s2_v_d;
            px_q   <= px_d;
            pz_q   <= pz_d;
            mag_q  <= mag_d;
            deg_q  <= deg_d;
            ovf_q  <= ovf_d;
        end
    end

    assign out_valid = s2_v_q;
    assign out_mag   = mag_q;
    assign out_deg   = deg_q;
    assign out_ovf   = ovf_q;

endmodule
